wb_host_master: RTL and testbench

WB_HOST_MASTER -- requirements
Module: wb_host_master

---
 rtl/wb_host_master.sv | 164 ++++++++++++++++
 tb/tb_wb_host_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_host_master
//  Purpose  : Single-outstanding command-to-Wishbone-classic bridge with an
//             optional bus timeout and a held response until it is consumed.
//  Revision : 1.0  initial release
// ============================================================================
module wb_host_master #(
  parameter int TIMEOUT = 255,  // BUS cycles without ack before abort; 0 = never
  parameter int TO_W    = 8     // timeout counter width; TIMEOUT must fit
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  // Wishbone master
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam bit            TO_EN    = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  // Ready is gated by reset so no command can be taken while reset is held.
  assign cmd_ready = (state_q == S_IDLE) && !wb_rst_i;
  assign busy      = (state_q != S_IDLE);

  // Cycle and strobe are always asserted together in classic single access.
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = 4'h0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          state_d     = S_RESP;
        end else if (TO_EN) begin
          // Terminating on reaching the limit keeps stb up for exactly
          // TIMEOUT cycles and means the counter can never wrap.
          if ((cnt_q + CNT_ONE) == TO_LIMIT) begin
            cyc_d       = 1'b0;
            we_d        = 1'b0;
            sel_d       = 4'h0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_dat_d   = 32'hFFFF_FFFF;
            state_d     = S_RESP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_host_master
//  Purpose  : Self-checking bench for wb_host_master (TIMEOUT = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_host_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [3:0]  cmd_sel = 4'h0;
  logic [31:0] cmd_adr = 32'h0, cmd_dat = 32'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i = 1'b0;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = 32'h0;
  logic        busy;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  wb_host_master #(.TIMEOUT(TO), .TO_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level reference: ack within the timeout window ends the
  // access at the ack cycle, otherwise it aborts after TO strobe cycles.
  function automatic void model(input int ack_at, input logic we, input logic [31:0] sdat,
                                output int cyc, output logic err, output logic [31:0] rdat);
    if (ack_at >= 1 && ack_at <= TO) begin
      cyc = ack_at; err = 1'b0; rdat = we ? 32'h0 : sdat;
    end else begin
      cyc = TO; err = 1'b1; rdat = 32'hFFFF_FFFF;
    end
  endfunction

  // One command: slave acks on strobe cycle ack_at (0 = never), response
  // is back-pressured for bp cycles with a spurious command and ack inside.
  task automatic do_txn(input string name, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat, input int ack_at,
                        input logic [31:0] sdat, input int bp, input int exp_cyc,
                        input logic exp_err, input logic [31:0] exp_rdat);
    int n = 0;
    chk({name, "_ready"}, {busy, cmd_ready}, {1'b0, 1'b1});
    cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel; cmd_we = ~we;
    while (wbm_stb_o && n < 64) begin
      n++;
      chk({name, "_bus"},
          {wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, busy, cmd_ready},
          {1'b1, we, sel, adr, dat, 1'b0, 1'b1, 1'b0});
      wbm_ack_i = (n == ack_at);
      wbm_dat_i = (n == ack_at) ? sdat : $urandom;
      @(negedge clk);
      wbm_ack_i = 1'b0;
    end
    chk({name, "_stb_cycles"}, n, exp_cyc);
    for (int i = 0; i < bp; i++) begin
      chk({name, "_hold"},
          {rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_cyc_o, wbm_stb_o, busy, wbm_adr_o, wbm_dat_o},
          {1'b1, exp_err, exp_rdat, 1'b0, 1'b0, 1'b0, 1'b1, adr, dat});
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_adr = $urandom; cmd_dat = $urandom;
        wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
      end
      @(negedge clk);
      cmd_valid = 1'b0; wbm_ack_i = 1'b0;
    end
    chk({name, "_rsp"}, {rsp_valid, rsp_err, rsp_dat}, {1'b1, exp_err, exp_rdat});
    chk({name, "_req_idle"},
        {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
        {1'b0, 1'b0, 1'b0, 4'h0, adr, dat});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_done"}, {rsp_valid, cmd_ready, busy}, {1'b0, 1'b1, 1'b0});
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          ack_at;
    logic [31:0] sdat;
    int          bp;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t tbl[7];
  logic [31:0] q_adr[3];
  int runs[$];
  int cur, idx, stb_seen, rsp_seen, e_cyc;
  logic pending, prev_stb, r_we, e_err;
  logic [3:0] r_sel;
  logic [31:0] r_adr, r_dat, r_sdat, e_rdat;
  int r_ack, r_bp, tot;

  initial begin
    tbl[0] = '{"wr0wait", 1'b1, 4'hF, 32'h3000_0004, 32'h0000_00A5, 1, 32'hDEAD_BEEF, 10, 1, 1'b0, 32'h0};
    tbl[1] = '{"rd3wait", 1'b0, 4'hF, 32'h1000_0010, 32'h0, 4, 32'h1234_5678, 0, 4, 1'b0, 32'h1234_5678};
    tbl[2] = '{"rd_to", 1'b0, 4'hF, 32'h2000_0000, 32'h0, 0, 32'h0, 0, 4, 1'b1, 32'hFFFF_FFFF};
    tbl[3] = '{"wr_to", 1'b1, 4'h3, 32'h2000_0008, 32'h1111_2222, 0, 32'h0, 2, 4, 1'b1, 32'hFFFF_FFFF};
    tbl[4] = '{"rd1wait", 1'b0, 4'h3, 32'h0000_0100, 32'h0, 2, 32'hCAFE_F00D, 0, 2, 1'b0, 32'hCAFE_F00D};
    tbl[5] = '{"wr_ack4", 1'b1, 4'h5, 32'h0000_0200, 32'h7777_8888, 4, 32'h0BAD_0BAD, 0, 4, 1'b0, 32'h0};
    tbl[6] = '{"rd_late", 1'b0, 4'hF, 32'h0000_0300, 32'h0, 5, 32'h5555_AAAA, 0, 4, 1'b1, 32'hFFFF_FFFF};

    // Reset: everything cleared and no command accepted while held.
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_state",
        {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
         rsp_valid, rsp_err, rsp_dat, busy, cmd_ready}, 128'h0);
    cmd_valid = 1'b1; cmd_adr = 32'h9999_0000;
    @(negedge clk);
    chk("reset_ignores_cmd", {wbm_cyc_o, busy, cmd_ready}, 3'b000);
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1 chk("reset_release_ready", cmd_ready, 1'b1);
    @(negedge clk);

    // Ack seen while idle must not disturb anything.
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0123_4567;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("idle_ack_ignored", {busy, rsp_valid, wbm_cyc_o, cmd_ready}, 4'b0001);

    for (int i = 0; i < 7; i++)
      do_txn(tbl[i].name, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat, tbl[i].ack_at,
             tbl[i].sdat, tbl[i].bp, tbl[i].exp_cyc, tbl[i].exp_err, tbl[i].exp_rdat);

    // Randomized accesses against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      r_we = 1'($urandom); r_sel = 4'($urandom); r_adr = $urandom; r_dat = $urandom;
      r_ack = int'($urandom_range(6, 0)); r_sdat = $urandom; r_bp = int'($urandom_range(3, 0));
      model(r_ack, r_we, r_sdat, e_cyc, e_err, e_rdat);
      do_txn("rand", r_we, r_sel, r_adr, r_dat, r_ack, r_sdat, r_bp, e_cyc, e_err, e_rdat);
    end

    // Reset between edges while strobe is up: bus drops immediately.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h5555_0000; cmd_dat = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midbus_stb_up", wbm_stb_o, 1'b1);
    #2 rst = 1'b1;
    #1 chk("midbus_reset_async",
           {wbm_cyc_o, wbm_stb_o, busy, cmd_ready, rsp_valid, wbm_adr_o}, 37'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midbus_release", {cmd_ready, rsp_valid, busy}, 3'b100);
    @(negedge clk);
    chk("midbus_no_rsp", {cmd_ready, rsp_valid, wbm_cyc_o}, 3'b100);

    // Back-to-back: three commands with cmd_valid held and a zero-wait slave.
    q_adr[0] = 32'h4000_0000; q_adr[1] = 32'h4000_0104; q_adr[2] = 32'h4000_0208;
    idx = 0; cur = 0; stb_seen = 0; rsp_seen = 0; pending = 1'b0; prev_stb = 1'b0;
    runs.delete();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = q_adr[0]; rsp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (pending) begin
        idx++;
        if (idx < 3) cmd_adr = q_adr[idx];
        else cmd_valid = 1'b0;
      end
      pending = cmd_valid && cmd_ready;
      if (cmd_ready) cur++;
      else if (cur > 0) begin runs.push_back(cur); cur = 0; end
      if (wbm_stb_o && !prev_stb) begin
        if (stb_seen < 3) chk("b2b_order", wbm_adr_o, q_adr[stb_seen]);
        stb_seen++;
      end
      prev_stb = wbm_stb_o;
      if (rsp_valid) begin
        if (rsp_seen < 3) chk("b2b_rdata", rsp_dat, {q_adr[rsp_seen][15:0], 16'h5A5A});
        rsp_seen++;
      end
      wbm_ack_i = wbm_stb_o;
      wbm_dat_i = {wbm_adr_o[15:0], 16'h5A5A};
      @(negedge clk);
    end
    wbm_ack_i = 1'b0; rsp_ready = 1'b0;
    tot = 0;
    foreach (runs[k]) tot += runs[k];
    chk("b2b_counts", {stb_seen, rsp_seen}, {32'd3, 32'd3});
    chk("b2b_ready_pulses", {runs.size(), tot}, {32'd3, 32'd3});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
